// File: rtl/full_add4.sv
// Registered WIDTH-bit ripple-carry adder: {cout, s} <= a + b + Cin, one cycle latency.
// Optional registered two's-complement overflow output ovf when FULL_ADD4_OVF_EN is defined.
module full_add4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] s,
   output logic             cout,
`ifdef FULL_ADD4_OVF_EN
   output logic             ovf,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Cin
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum;

   assign c[0] = Cin;

   // One full-adder cell per bit; c[i+1] is the carry out of cell i.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s    <= '0;
         cout <= 1'b0;
`ifdef FULL_ADD4_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         s    <= sum;
         cout <= c[WIDTH];
`ifdef FULL_ADD4_OVF_EN
         ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
   end

endmodule

// File: tb/tb_full_add4.sv
// Scoreboard bench for full_add4: driver pushes expected results, a monitor pops one per edge.
// Covers FULL_ADD4_OVF_EN when the macro is defined for both files.
module tb_full_add4;

   localparam int W = 4;

   typedef struct {
      logic [W:0] sum;
      logic       ovf;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] s;
   logic         cout;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef FULL_ADD4_OVF_EN
   logic         ovf;
`endif

   exp_t q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   full_add4 #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .s    (s),
      .cout (cout),
`ifdef FULL_ADD4_OVF_EN
      .ovf  (ovf),
`endif
      .a    (a),
      .b    (b),
      .Cin  (cin)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Apply operands on the falling edge and record what the next rising edge must produce.
   task automatic drive(input logic r, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv);
      exp_t e;
      logic [W:0] tot;
      @(negedge clk);
      rst = r;
      a   = av;
      b   = bv;
      cin = cv;
      tot = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      if (r) begin
         e.sum = '0;
         e.ovf = 1'b0;
      end else begin
         e.sum = tot;
         e.ovf = (av[W-1] == bv[W-1]) && (tot[W-1] != av[W-1]);
      end
      q.push_back(e);
   endtask

   // Monitor: entries queued before a rising edge are due on that edge's output.
   initial begin
      int unsigned pend;
      exp_t e;
      forever begin
         @(posedge clk);
         pend = q.size();
         @(negedge clk);
         if (pend > 0) begin
            e = q.pop_front();
            check("sum", {27'd0, cout, s}, {27'd0, e.sum});
`ifdef FULL_ADD4_OVF_EN
            check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
         end
      end
   end

   initial begin
      rst = 1'b1;
      a   = 4'd9;
      b   = 4'd9;
      cin = 1'b1;
      #1;
      check("reset_s", {28'd0, s}, 32'd0);
      check("reset_cout", {31'd0, cout}, 32'd0);

      repeat (3) drive(1'b1, 4'd9, 4'd9, 1'b1);
      drive(1'b0, 4'd9, 4'd9, 1'b1);            // 19 -> s=3, cout=1

      for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 4'(i), 1'b0);

      drive(1'b0, 4'd8,  4'd8,  1'b0);          // s=0, cout=1
      drive(1'b0, 4'd15, 4'd0,  1'b1);          // s=0, cout=1
      drive(1'b0, 4'd15, 4'd15, 1'b1);          // s=15, cout=1
      drive(1'b0, 4'd7,  4'd5,  1'b1);          // s=13, cout=0

      for (int i = 0; i < 512; i++) drive(1'b0, 4'(i >> 5), 4'(i >> 1), i[0]);

      // Mid-stream asynchronous reset, pulsed between edges after 7 + 1 is registered.
      drive(1'b0, 4'd7, 4'd1, 1'b0);
      @(negedge clk);
      #1;
      check("pre_rst_s", {28'd0, s}, 32'd8);
`ifdef FULL_ADD4_OVF_EN
      check("pre_rst_ovf", {31'd0, ovf}, 32'd1);
`endif
      rst = 1'b1;
      #1;
      check("async_s", {28'd0, s}, 32'd0);
      check("async_cout", {31'd0, cout}, 32'd0);
`ifdef FULL_ADD4_OVF_EN
      check("async_ovf", {31'd0, ovf}, 32'd0);
`endif
      #1;
      rst = 1'b0;

      drive(1'b0, 4'd3, 4'd4, 1'b1);            // s=8, cout=0 after recovery
      drive(1'b0, 4'd12, 4'd6, 1'b0);           // 18 -> s=2, cout=1

      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/full_add4.md
Name:
full_add4

Overview:
- Registered WIDTH-bit ripple-carry adder: s/cout = a + b + Cin, captured on the clock edge.
- Built as a generate chain of 1-bit full-adder cells (sum = a^b^c, carry = ab | c(a^b)) feeding an output register.
- Used as the 4-bit add primitive in datapath blocks; default WIDTH = 4.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- s  output  WIDTH  registered sum, a + b + Cin modulo 2^WIDTH.
- cout  output  1  registered carry out of the MSB cell.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- Cin  input  1  carry in to the LSB cell.
- Positional order after clk, rst: s, cout, a, b, Cin.

Behaviour:
- Reset:
  - rst high clears s to 0 and cout to 0 immediately, independent of clk.
  - Outputs hold 0 while rst is high.
  - Reset asserted mid-operation discards the pending result.
  - First valid result appears on the first rising clk edge after rst deasserts.
- Datapath:
  - Combinational ripple chain: c[0] = Cin; for i = 0..WIDTH-1: sum[i] = a[i]^b[i]^c[i], c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - {cout, s} must equal the WIDTH+1-bit unsigned sum a + b + Cin.
- Latency and throughput:
  - Exactly 1 cycle: operands present before edge N produce {cout, s} after edge N.
  - New operands accepted every cycle; no handshake; no stall.
- Wrap-around: sums >= 2^WIDTH set cout = 1, and s holds the low WIDTH bits. Example: 15 + 0 + 1 gives s = 0, cout = 1.
- Max case: a = b = all ones, Cin = 1 gives s = all ones, cout = 1.
- X/Z on inputs is not resolved; the bench must drive known values.
- No internal state other than the output register.

Optional Feature:
- Macro FULL_ADD4_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), placed after cout.
  - ovf is the registered two's-complement overflow, c[WIDTH] ^ c[WIDTH-1].
  - ovf resets to 0 and has the same 1-cycle latency as s.
- When undefined:
  - Port ovf and its logic are absent.
  - Port list is exactly clk, rst, s, cout, a, b, Cin.

Test Plan:
- Reset: rst = 1 with a = 9, b = 9, Cin = 1, clock running -> s = 0, cout = 0 throughout; after deassert, next edge gives s = 3, cout = 1.
- Sweep: a = 0, Cin = 0, b = 0..15 one value per cycle -> each s equals b one cycle later, cout = 0.
- Carry: a = 8, b = 8, Cin = 0 -> s = 0, cout = 1; a = 15, b = 0, Cin = 1 -> s = 0, cout = 1.
- Max: a = 15, b = 15, Cin = 1 -> s = 15, cout = 1; a = 7, b = 5, Cin = 1 -> s = 13, cout = 0.
- Exhaustive: all 512 combinations of a, b, Cin back-to-back -> {cout, s} = a + b + Cin, delayed exactly 1 cycle.
- Async reset mid-stream with FULL_ADD4_OVF_EN: a = 7, b = 1 -> ovf = 1, s = 8; pulse rst between edges -> s, cout, ovf go to 0 immediately, before the next edge.
